line_memory: RTL and testbench
==============================

Name: line_memory

Overview:
- Backing-store controller directly downstream of the data cache and instruction cache.
- Serves whole cache-line reads (refills) and writes (dirty write-backs).
- Models fixed main-memory latency and arbitrates between the two cache ports.
- Answers each request with a one-cycle ready pulse, which both caches sample as their memory-ready input.

Parameters:
- CACHE_LINE_SIZE, 128, line width in bits; must equal the caches' line size.
- MEM_LINES, 256, number of lines stored; power of two.
- MEM_LATENCY, 5, cycles from request acceptance to ready pulse; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- d_read_en  input  1  dcache line-read request; level, held until d_ready.
- d_write_en  input  1  dcache line-write request; level, held until d_ready.
- d_addr  input  32  dcache line address; bits [3:0] ignored.
- d_write_data  input  CACHE_LINE_SIZE  line to write.
- d_read_data  output  CACHE_LINE_SIZE  line returned to dcache.
- d_ready  output  1  one-cycle completion pulse to dcache.
- i_read_en  input  1  icache line-read request; level, held until i_ready.
- i_addr  input  32  icache line address; bits [3:0] ignored.
- i_read_data  output  CACHE_LINE_SIZE  line returned to icache.
- i_ready  output  1  one-cycle completion pulse to icache.

Behaviour:
- Storage: MEM_LINES x CACHE_LINE_SIZE array.
  - Line index = addr[4 +: log2(MEM_LINES)]; higher address bits are ignored, so addresses wrap modulo MEM_LINES.
  - Array is zero at time 0 and is NOT cleared by reset.
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, last_grant=I.
  - d_ready=0, i_ready=0, d_read_data=0, i_read_data=0.
  - An in-flight operation is aborted; no write is committed.
- States:
  - IDLE: no operation in flight.
  - BUSY: latency counting.
  - RESP: completion cycle, ready high.
- IDLE:
  - dcache request = d_read_en|d_write_en; icache request = i_read_en.
  - Only one side requesting: that side is granted.
  - Both requesting: the side not in last_grant wins (round-robin); last_grant is updated to the winner.
  - Grant latches port, address, op and write data.
  - Op select: d_write_en takes precedence over d_read_en when both are high (treated as write).
  - MEM_LATENCY=1: go directly to RESP.
  - Otherwise: counter <= MEM_LATENCY-1, go to BUSY.
- BUSY:
  - counter decrements each cycle.
  - When counter==1, next state is RESP.
  - Request inputs are ignored while in BUSY.
- Entering RESP (same edge):
  - Write: array[index] <= latched write data.
  - Read: the granted port's read_data <= array[index].
- RESP:
  - Granted port's ready=1 for exactly this cycle; next state is IDLE.
- Timing: ready is high in the cycle starting MEM_LATENCY edges after the acceptance edge.
- Back-to-back and hold rules:
  - The requester drops its enable at the edge that samples ready, so IDLE never re-grants a completed request.
  - IDLE accepts a new request in the cycle immediately after RESP; no bubble is required.
- Read-data hold: each port's read_data holds its last returned line until that port's next read completes. Writes do not modify d_read_data.
- Enable dropped mid-operation (flush): the operation still completes, with the array update and ready pulse as normal.
- The ungranted port's ready stays 0 throughout.

Test Plan:
- Reset, then dcache read of 0x0000_0040 (array zero) -> d_ready high exactly 5 cycles after acceptance for 1 cycle; d_read_data=0; i_ready stays 0.
- dcache write 0x0000_0050 with data 0x0123..CDEF, then dcache read 0x0000_005C -> same line returned; bits [3:0] ignored.
- d_read_en and i_read_en raised in the same cycle after reset -> dcache granted first (last_grant=I); i_ready pulses exactly 6 cycles after d_ready (1 cycle in RESP + 5 latency), with no re-grant of dcache.
- Write to 0x0000_1050 with MEM_LINES=256 -> read of 0x0000_0050 returns the written line (wrap-around).
- Pull reset low 2 cycles into a dcache write -> no ready pulse; after release, a read of that line returns the old contents.
- MEM_LATENCY=1 build: dcache read -> d_ready high in the cycle after acceptance; back-to-back dcache and icache requests are serviced on alternate RESP/IDLE cycles.

Source files
------------

// File: rtl/line_memory.sv
// line_memory: latency-modelled line store arbitrating dcache/icache refills and write-backs
module line_memory #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_LINES       = 256,
  parameter int MEM_LATENCY     = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       d_read_en,
  input  logic                       d_write_en,
  input  logic [31:0]                d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] d_write_data,
  output logic [CACHE_LINE_SIZE-1:0] d_read_data,
  output logic                       d_ready,
  input  logic                       i_read_en,
  input  logic [31:0]                i_addr,
  output logic [CACHE_LINE_SIZE-1:0] i_read_data,
  output logic                       i_ready
);
  localparam int IW = $clog2(MEM_LINES);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_last_d, r_port_d, r_write;
  logic [IW-1:0] r_idx;
  logic [CACHE_LINE_SIZE-1:0] r_wdata;
  logic [CACHE_LINE_SIZE-1:0] r_mem [MEM_LINES] = '{default: '0};
  logic w_d_req, w_grant_d, w_accept, w_enter, w_op_d, w_op_write, w_unused;
  logic [IW-1:0] w_op_idx;
  logic [CACHE_LINE_SIZE-1:0] w_op_wdata;
  assign w_unused = ^{d_addr, i_addr};
  assign d_ready  = (r_state == RESP) & r_port_d;
  assign i_ready  = (r_state == RESP) & ~r_port_d;
  // round-robin grant, next state, and the operation seen at the edge entering RESP
  always_comb begin
    w_d_req   = d_read_en | d_write_en;
    w_grant_d = w_d_req & (~i_read_en | ~r_last_d);
    w_accept  = (r_state == IDLE) & (w_d_req | i_read_en);
    w_next    = IDLE;
    if (r_state == IDLE && w_accept) w_next = (MEM_LATENCY == 1) ? RESP : BUSY;
    if (r_state == BUSY) w_next = (r_cnt == CW'(1)) ? RESP : BUSY;
    w_enter    = (w_next == RESP);
    w_op_d     = (r_state == IDLE) ? w_grant_d : r_port_d;
    w_op_write = (r_state == IDLE) ? (w_grant_d & d_write_en) : r_write;
    w_op_idx   = (r_state == IDLE) ? (w_grant_d ? d_addr[4 +: IW] : i_addr[4 +: IW]) : r_idx;
    w_op_wdata = (r_state == IDLE) ? d_write_data : r_wdata;
  end
  // control state and read-data returns; reset aborts any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last_d    <= 1'b0;
      r_port_d    <= 1'b0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      d_read_data <= '0;
      i_read_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt    <= CW'(MEM_LATENCY - 1);
        r_port_d <= w_grant_d;
        r_write  <= w_grant_d & d_write_en;
        r_idx    <= w_op_idx;
        r_wdata  <= d_write_data;
        if (w_d_req & i_read_en) r_last_d <= w_grant_d;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_enter & ~w_op_write & w_op_d) d_read_data <= r_mem[w_op_idx];
      if (w_enter & ~w_op_write & ~w_op_d) i_read_data <= r_mem[w_op_idx];
    end
  end
  // line array: never cleared, committed on the edge entering RESP unless reset is held
  always_ff @(posedge clk) begin
    if (reset & w_enter & w_op_write) r_mem[w_op_idx] <= w_op_wdata;
  end
endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: randomized transaction-level check of line_memory at latencies 5 and 1
module tb_line_memory;
  localparam int W = 128;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d_read_en = 1'b0, d_write_en = 1'b0, i_read_en = 1'b0;
  logic [31:0] d_addr = '0, i_addr = '0;
  logic [W-1:0] d_write_data = '0;
  logic [W-1:0] d_rd5, i_rd5, d_rd1, i_rd1, d_rd, i_rd;
  logic d_rdy5, i_rdy5, d_rdy1, i_rdy1, d_rdy, i_rdy;
  int n_chk = 0, n_pass = 0;
  bit sel1 = 1'b0;
  logic [W-1:0] mem [256];
  logic [W-1:0] d_last, i_last;
  bit last_d;
  always #5 clk = ~clk;
  assign d_rdy = sel1 ? d_rdy1 : d_rdy5;
  assign i_rdy = sel1 ? i_rdy1 : i_rdy5;
  assign d_rd  = sel1 ? d_rd1 : d_rd5;
  assign i_rd  = sel1 ? i_rd1 : i_rd5;
  line_memory #(.MEM_LATENCY(5)) u_dut (
    .clk(clk), .reset(reset), .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr),
    .d_write_data(d_write_data), .d_read_data(d_rd5), .d_ready(d_rdy5), .i_read_en(i_read_en),
    .i_addr(i_addr), .i_read_data(i_rd5), .i_ready(i_rdy5));
  line_memory #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr),
    .d_write_data(d_write_data), .d_read_data(d_rd1), .d_ready(d_rdy1), .i_read_en(i_read_en),
    .i_addr(i_addr), .i_read_data(i_rd1), .i_ready(i_rdy1));

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_reset();
    d_read_en = 1'b0;
    d_write_en = 1'b0;
    i_read_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_d_ready", W'(d_rdy), '0);
    chk("rst_i_ready", W'(i_rdy), '0);
    chk("rst_d_data", d_rd, '0);
    chk("rst_i_data", i_rd, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    d_last = '0;
    i_last = '0;
    last_d = 1'b0;
  endtask

  task automatic xact(input bit dq, input bit dw, input bit iq, input logic [31:0] da,
                      input logic [31:0] ia, input logic [W-1:0] wd);
    int lat, n;
    bit first_d, dd, id;
    lat = sel1 ? 1 : 5;
    first_d = dq && !(iq && last_d);
    if (dq && iq) last_d = first_d;
    d_read_en = dq && !dw;
    d_write_en = dq && dw;
    d_addr = da;
    i_addr = ia;
    d_write_data = wd;
    i_read_en = iq;
    dd = !dq;
    id = !iq;
    n = 0;
    while (!(dd && id) && n < 4 * lat + 8) begin
      @(negedge clk);
      n++;
      if (d_rdy) begin
        if (dd) chk("d_spurious", W'(d_rdy), '0);
        else begin
          chk("d_latency", W'(n), W'(first_d ? lat : 2 * lat + 1));
          if (dw) mem[da[11:4]] = wd;
          else d_last = mem[da[11:4]];
          chk("d_data", d_rd, d_last);
          d_read_en = 1'b0;
          d_write_en = 1'b0;
          dd = 1'b1;
        end
      end
      if (i_rdy) begin
        if (id) chk("i_spurious", W'(i_rdy), '0);
        else begin
          chk("i_latency", W'(n), W'(first_d ? 2 * lat + 1 : lat));
          i_last = mem[ia[11:4]];
          chk("i_data", i_rd, i_last);
          i_read_en = 1'b0;
          id = 1'b1;
        end
      end
    end
    if (!(dd && id)) chk("ready_timeout", '0, W'(1));
    @(negedge clk);
    chk("ready_pulse_end", W'({d_rdy, i_rdy}), '0);
  endtask

  task automatic rnd_xact();
    bit dq, iq, dw;
    logic [31:0] da, ia;
    dq = 1'($urandom_range(0, 1));
    iq = dq ? 1'($urandom_range(0, 1)) : 1'b1;
    dw = 1'($urandom_range(0, 1));
    da = $urandom;
    ia = $urandom;
    da[11:4] = 8'($urandom_range(0, 7));
    ia[11:4] = 8'($urandom_range(0, 7));
    xact(dq, dw, iq, da, ia, {$urandom, $urandom, $urandom, $urandom});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    do_reset();
    xact(1, 0, 0, 32'h0000_0040, '0, '0);
    xact(1, 1, 0, 32'h0000_0050, '0, 128'h0123456789ABCDEF0123456789ABCDEF);
    xact(1, 0, 0, 32'h0000_005C, '0, '0);
    do_reset();
    xact(1, 0, 1, 32'h0000_0050, 32'h0000_0040, '0);
    xact(1, 1, 0, 32'h0000_1050, '0, {$urandom, $urandom, $urandom, $urandom});
    xact(1, 0, 0, 32'h0000_0050, '0, '0);
    d_write_en = 1'b1;
    d_addr = 32'h0000_0300;
    d_write_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_ready", W'(d_rdy), '0);
    end
    xact(1, 0, 0, 32'h0000_0300, '0, '0);
    repeat (60) rnd_xact();
    sel1 = 1'b1;
    do_reset();
    xact(1, 0, 0, 32'h0000_0050, '0, '0);
    xact(1, 0, 1, 32'h0000_0040, 32'h0000_0050, '0);
    xact(1, 1, 1, 32'h0000_0060, 32'h0000_0060, {$urandom, $urandom, $urandom, $urandom});
    repeat (40) rnd_xact();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
